fft_frame_sequencer: RTL and testbench
======================================

# fft_frame_sequencer

Parametrised frame sequencer for an N-point FFT core. It collects a serial stream of complex samples into an N-word frame and presents the frame in parallel to an external pipelined FFT core. It captures the core result and replays it serially with valid/ready handshakes and frame markers. It supersedes the fixed 16-point shift-register wrapper with backpressure, frame boundaries and a core-latency parameter.

## Interface
- `N`, default 16: frame length in points; power of two, 4..64.
- `W`, default 32: sample width; real part in `[W-1:W/2]`, imaginary part in `[W/2-1:0]`, both signed two's complement.
- `CORE_LAT`, default 1: FFT core pipeline latency in cycles, 0..15.
- `CLK` in 1: single clock; all logic on rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `IN_VALID` in 1: input sample valid.
- `IN_DATA` in W: input sample.
- `IN_READY` out 1: block accepts a sample this cycle.
- `OUT_VALID` out 1: output sample valid.
- `OUT_DATA` out W: output sample.
- `OUT_FIRST` out 1: output word is bin 0 of a frame.
- `OUT_LAST` out 1: output word is bin N-1 of a frame.
- `OUT_READY` in 1: downstream accepts an output sample.
- `CORE_X` out N*W: frame to core; slot k is `[k*W+W-1:k*W]`.
- `CORE_Y` in N*W: core result with the same slot layout, valid `CORE_LAT` cycles after `CORE_X` is stable.

## Operation
- Input transfer: `IN_VALID && IN_READY` at a rising edge. The k-th accepted sample of a frame (k=0..N-1) is written to slot k of `CORE_X`. `in_cnt` counts 0..N-1.
- Output transfer: `OUT_VALID && OUT_READY`. Words leave in slot order 0..N-1.
- Input FSM states:
  - FILL: `IN_READY`=1. Accepting sample N-1 moves the FSM to COMPUTE with `lat_cnt`=0.
  - COMPUTE: `IN_READY`=0 and `CORE_X` frozen. `lat_cnt` increments each cycle. When `lat_cnt`==`CORE_LAT`, the FSM loads `CORE_Y` into the output buffer and returns to FILL if the output buffer is free; otherwise it moves to HOLD.
  - HOLD: `IN_READY`=0. It loads and returns to FILL as soon as the output buffer is free.
- The output buffer is free when it is empty, or when its `OUT_LAST` word transfers in the same cycle. Loading in that case is seamless: the next cycle presents slot 0 of the new frame.
- The output side drains one frame while the input side fills the next.
- `OUT_DATA` is don't-care when `OUT_VALID`=0.
- `IN_VALID` gaps and `OUT_READY` stalls may occur in any cycle. Counters advance only on transfers.
- Reset mid-operation: the partial input frame, any in-flight core result and any undrained output are discarded, and all counters are cleared.

## Timing
- Reset values:
  - `IN_READY`=0 while `RESET` is high; it is 1 in the first cycle after release.
  - `OUT_VALID`=0, `OUT_FIRST`=0, `OUT_LAST`=0.
  - `OUT_DATA`=0 and `CORE_X`=0.
  - FSM=FILL, all counters 0.
- Latency: the edge that accepts sample N-1 is edge e. The load happens at edge e+`CORE_LAT`+1 when output is free, and `OUT_VALID` is high in the following cycle.
- Continuous input with `OUT_READY`=1: `IN_READY` is low for exactly `CORE_LAT`+1 cycles between frames, so the frame period is N+`CORE_LAT`+1.

## Configuration
- `FFT_OUT_SCALE_EN` defined: at load, the real and imaginary parts of each slot are each arithmetic-shifted right by log2(N) (floor rounding), giving 1/N-normalised output.
- Not defined: `CORE_Y` is passed through unmodified.

## Structure
- Package `fft_frame_pkg`:
  - FSM state enum (FILL, COMPUTE, HOLD).
  - `clog2`-based width constants for `in_cnt`, `out_cnt` and `lat_cnt`.
  - Complex-split helper for the re/im halves.
- Sub-module `fft_frame_unload`: output buffer, `out_cnt`, `OUT_VALID`/`OUT_FIRST`/`OUT_LAST` generation, and the optional scaling. It exports `free` to the input FSM.
- The FFT core stays outside this block and connects via `CORE_X`/`CORE_Y`.

## Test plan
All scenarios use N=16, W=32, `CORE_LAT`=2, and a loopback core (`CORE_Y` = `CORE_X` delayed 2 cycles) unless noted.
- Reset: `RESET`=1 for 3 cycles with `IN_VALID`=1 -> `IN_READY`=0, `OUT_VALID`=0, `CORE_X`=0; `IN_READY`=1 in the first cycle after release.
- Single frame: input 0x00000001..0x00000010 back-to-back -> `CORE_X` slot k = k+1; `OUT_VALID` is high 3 edges after the last accept; output is 1..16 with `OUT_FIRST` on 1 and `OUT_LAST` on 16.
- Streaming: 3 frames with continuous `IN_VALID` and `OUT_READY`=1 -> `IN_READY` low exactly 3 cycles per gap; output frames are contiguous and in order. The same test with `IN_VALID` toggling each cycle -> identical data.
- Backpressure: `OUT_READY`=0 during frame 1 output, second frame fully input -> FSM in HOLD with `IN_READY`=0. Raising `OUT_READY` -> load on the edge frame 1's `OUT_LAST` transfers, and frame 2 slot 0 is valid the next cycle.
- Mid-operation reset: `RESET` pulse after 7 input samples while output word 5 is pending -> `OUT_VALID`=0. The next 16 samples form a fresh frame starting at slot 0.
- Scaling with `FFT_OUT_SCALE_EN`: `CORE_Y` slot 0 = 0x80000010 -> `OUT_DATA` = 0xF8000001. Without the macro -> 0x80000010.

Source files
------------

// File: rtl/fft_frame_pkg.sv
// Shared types, counter widths and the complex re/im split helper for the
// FFT frame sequencer.
package fft_frame_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } seq_state_e;

    localparam int unsigned MAX_W = 64;
    localparam int unsigned LAT_W = $clog2(16);

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sign-extends the re/im halves of a w-bit word held in the low bits of 'word'.
    function automatic void cplx_split(
        input  logic [MAX_W-1:0]          word,
        input  int unsigned               w,
        output logic signed [MAX_W/2-1:0] re,
        output logic signed [MAX_W/2-1:0] im
    );
        int unsigned h;
        h = w / 2;
        for (int unsigned b = 0; b < MAX_W / 2; b++) begin
            im[b] = (b < h) ? word[b]     : word[h-1];
            re[b] = (b < h) ? word[h + b] : word[w-1];
        end
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Stream-in, stream-out and core-facing signals of the FFT frame sequencer.
interface fft_frame_sequencer_if #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 32
);
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_first;
    logic           out_last;
    logic           out_ready;
    logic [N*W-1:0] core_x;
    logic [N*W-1:0] core_y;

    modport slave (
        input  in_valid, in_data, out_ready, core_y,
        output in_ready, out_valid, out_data, out_first, out_last, core_x
    );

    modport master (
        output in_valid, in_data, out_ready, core_y,
        input  in_ready, out_valid, out_data, out_first, out_last, core_x
    );
endinterface

// File: rtl/fft_frame_unload.sv
// Output frame buffer and serial replay. With FFT_OUT_SCALE_EN defined each
// re/im half is arithmetic-shifted right by log2(N) when the frame is loaded.
module fft_frame_unload
    import fft_frame_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned W = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load_i,
    input  logic [N*W-1:0] frame_i,
    input  logic           out_ready_i,
    output logic           out_valid_o,
    output logic [W-1:0]   out_data_o,
    output logic           out_first_o,
    output logic           out_last_o,
    output logic           free_o
);
    localparam int unsigned CNT_W = cnt_width(N);

    logic [N*W-1:0] frame_s;
    logic [N*W-1:0] buf_d, buf_q;
    logic [CNT_W-1:0] cnt_d, cnt_q, cnt_nxt_s;
    logic [W-1:0]   data_d, data_q;
    logic           valid_d, valid_q;
    logic           first_d, first_q;
    logic           last_d, last_q;
    logic           xfer_s;

`ifdef FFT_OUT_SCALE_EN
    localparam int unsigned LOG2N = $clog2(N);
    logic signed [MAX_W/2-1:0] re_s, im_s;

    // 1/N normalisation of every slot on its way into the buffer
    always_comb begin
        frame_s = '0;
        re_s    = '0;
        im_s    = '0;
        for (int k = 0; k < N; k++) begin
            cplx_split(MAX_W'(frame_i[k*W +: W]), W, re_s, im_s);
            re_s = re_s >>> LOG2N;
            im_s = im_s >>> LOG2N;
            frame_s[k*W +: W] = {re_s[W/2-1:0], im_s[W/2-1:0]};
        end
    end
`else
    assign frame_s = frame_i;
`endif

    assign xfer_s = valid_q && out_ready_i;
    // A frame may be loaded in the same cycle its predecessor's last word leaves.
    assign free_o = !valid_q || (xfer_s && last_q);

    // Buffer load, word advance and frame marker generation
    always_comb begin
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        first_d   = first_q;
        last_d    = last_q;
        cnt_nxt_s = cnt_q + 1'b1;
        if (load_i) begin
            buf_d   = frame_s;
            cnt_d   = '0;
            data_d  = frame_s[W-1:0];
            valid_d = 1'b1;
            first_d = 1'b1;
            last_d  = 1'b0;
        end else if (xfer_s) begin
            if (last_q) begin
                cnt_d   = '0;
                valid_d = 1'b0;
                first_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                cnt_d   = cnt_nxt_s;
                data_d  = buf_q[cnt_nxt_s*W +: W];
                first_d = 1'b0;
                last_d  = (cnt_nxt_s == CNT_W'(N - 1));
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output buffer registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_first_o = first_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Collects N serial samples into a frame for an external FFT core, waits
// CORE_LAT cycles, then hands the core result to the unload buffer.
// Optional feature macro: FFT_OUT_SCALE_EN (output scaling in fft_frame_unload).
module fft_frame_sequencer
    import fft_frame_pkg::*;
#(
    parameter int unsigned N        = 16,
    parameter int unsigned W        = 32,
    parameter int unsigned CORE_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fft_frame_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W = cnt_width(N);

    seq_state_e     state_d, state_q;
    logic [CNT_W-1:0] in_cnt_d, in_cnt_q;
    logic [LAT_W-1:0] lat_cnt_d, lat_cnt_q;
    logic [N*W-1:0] core_x_d, core_x_q;
    logic           load_s;
    logic           free_s;

    // Input FSM: fill, wait out the core latency, then hand off when unload is free
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        lat_cnt_d = lat_cnt_q;
        core_x_d  = core_x_q;
        load_s    = 1'b0;
        case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    core_x_d[in_cnt_q*W +: W] = bus.in_data;
                    if (in_cnt_q == CNT_W'(N - 1)) begin
                        in_cnt_d  = '0;
                        lat_cnt_d = '0;
                        state_d   = COMPUTE;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end else begin
                    in_cnt_d = in_cnt_q;
                end
            end
            COMPUTE: begin
                if (lat_cnt_q == LAT_W'(CORE_LAT)) begin
                    lat_cnt_d = '0;
                    if (free_s) begin
                        load_s  = 1'b1;
                        state_d = FILL;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (free_s) begin
                    load_s  = 1'b1;
                    state_d = FILL;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Input FSM and frame registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= FILL;
            in_cnt_q  <= '0;
            lat_cnt_q <= '0;
            core_x_q  <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            lat_cnt_q <= lat_cnt_d;
            core_x_q  <= core_x_d;
        end
    end

    // Gated by reset so the block never advertises space while held in reset.
    assign bus.in_ready = (state_q == FILL) && !rst_i;
    assign bus.core_x   = core_x_q;

    fft_frame_unload #(
        .N (N),
        .W (W)
    ) u_unload (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (load_s),
        .frame_i     (bus.core_y),
        .out_ready_i (bus.out_ready),
        .out_valid_o (bus.out_valid),
        .out_data_o  (bus.out_data),
        .out_first_o (bus.out_first),
        .out_last_o  (bus.out_last),
        .free_o      (free_s)
    );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a 2-cycle loopback core.
module tb_fft_frame_sequencer;
    import fft_frame_pkg::*;

    localparam int N   = 16;
    localparam int W   = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_frame_sequencer_if #(.N(N), .W(W)) bus ();

    fft_frame_sequencer #(.N(N), .W(W), .CORE_LAT(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [N*W-1:0] d1 = '0;
    logic [N*W-1:0] d2 = '0;
    always @(posedge clk) begin
        d1 <= bus.core_x;
        d2 <= d1;
    end
    assign bus.core_y = d2;

    int          cyc = 0;
    logic [31:0] mon_data[$];
    bit          mon_first[$];
    bit          mon_last[$];
    int          mon_cyc[$];
    int          gaps[$];
    int          low_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Records output transfers and lengths of IN_READY-low runs
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            mon_data.push_back(bus.out_data);
            mon_first.push_back(bus.out_first);
            mon_last.push_back(bus.out_last);
            mon_cyc.push_back(cyc);
        end
        if (!rst && !bus.in_ready) low_run <= low_run + 1;
        else if (low_run > 0) begin
            gaps.push_back(low_run);
            low_run <= 0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input bit gap);
        int waited;
        waited = 0;
        if (gap) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (waited >= 200) check("in_ready_timeout", 64'd0, 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int b;
        b = 0;
        while (mon_data.size() < n && b < 600) begin
            tick();
            b++;
        end
        if (b >= 600) check("out_timeout", mon_data.size(), n);
    endtask

    task automatic wait_valid();
        int b;
        b = 0;
        while (!bus.out_valid && b < 100) begin
            tick();
            b++;
        end
        if (b >= 100) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_frame(input string tag, input int start, input logic [31:0] base);
        for (int k = 0; k < N; k++) begin
            if (start + k >= mon_data.size()) begin
                check($sformatf("%s_missing%0d", tag, k), mon_data.size(), start + k + 1);
                return;
            end
            check($sformatf("%s_d%0d", tag, k), mon_data[start+k], base + k);
            check($sformatf("%s_f%0d", tag, k), mon_first[start+k], (k == 0));
            check($sformatf("%s_l%0d", tag, k), mon_last[start+k], (k == N - 1));
        end
    endtask

    task automatic clear_mon();
        mon_data.delete();
        mon_first.delete();
        mon_last.delete();
        mon_cyc.delete();
        gaps.delete();
    endtask

    task automatic stream3(input bit gap, input string tag);
        clear_mon();
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < N; k++)
                push(32'h0001_0000 * (f + 1) + k, gap);
        wait_out(3 * N);
        for (int f = 0; f < 3; f++) begin
            check_frame($sformatf("%s%0d", tag, f), f * N, 32'h0001_0000 * (f + 1));
            if (mon_cyc.size() >= (f + 1) * N)
                check($sformatf("%s_contig%0d", tag, f), mon_cyc[f*N+N-1] - mon_cyc[f*N], N - 1);
        end
        check({tag, "_ngaps"}, gaps.size(), 3);
        for (int g = 0; g < gaps.size(); g++)
            check($sformatf("%s_gap%0d", tag, g), gaps[g], LAT + 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] exp0, exp1, exp2;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEAD_BEEF;
        bus.out_ready = 1'b0;

        // Reset held for 3 cycles with IN_VALID high
        tick();
        tick();
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_core_x_zero", (bus.core_x == '0), 1'b1);
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rel_in_ready", bus.in_ready, 1'b1);
        check("rel_out_first", bus.out_first, 1'b0);
        check("rel_out_last", bus.out_last, 1'b0);
        check("rel_out_data", bus.out_data, 32'h0);

        // Single frame
        clear_mon();
        bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) push(32'h1 + k, 1'b0);
        for (int k = 0; k < N; k++)
            check($sformatf("single_core_x%0d", k), bus.core_x[k*W +: W], 32'h1 + k);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.out_valid && n < 20);
        check("single_latency", n, LAT + 1);
        wait_out(N);
        check_frame("single", 0, 32'h1);
        check("single_ngaps", gaps.size(), 1);
        if (gaps.size() > 0) check("single_gap", gaps[0], LAT + 1);

        // Streaming, continuous then toggling IN_VALID
        stream3(1'b0, "strm");
        if (mon_cyc.size() >= N + 1) check("strm_period", mon_cyc[N] - mon_cyc[0], N + LAT + 1);
        stream3(1'b1, "tog");

        // Backpressure into HOLD, then seamless release
        clear_mon();
        bus.out_ready = 1'b0;
        for (int k = 0; k < N; k++) push(32'h100 + k, 1'b0);
        wait_valid();
        for (int k = 0; k < N; k++) push(32'h200 + k, 1'b0);
        repeat (8) tick();
        check("bp_state", dut.state_q, HOLD);
        check("bp_in_ready", bus.in_ready, 1'b0);
        check("bp_out_data", bus.out_data, 32'h100);
        check("bp_out_first", bus.out_first, 1'b1);
        bus.out_ready = 1'b1;
        wait_out(2 * N);
        check_frame("bp1", 0, 32'h100);
        check_frame("bp2", N, 32'h200);
        if (mon_cyc.size() >= N + 1) begin
            check("bp_seamless", mon_cyc[N] - mon_cyc[N-1], 1);
            check("bp_contig", mon_cyc[N] - mon_cyc[0], N);
        end

        // Reset during partial input and pending output
        clear_mon();
        bus.out_ready = 1'b0;
        for (int k = 0; k < N; k++) push(32'h300 + k, 1'b0);
        wait_valid();
        bus.out_ready = 1'b1;
        repeat (5) tick();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 7; k++) push(32'h400 + k, 1'b0);
        check("mr_pending_data", bus.out_data, 32'h305);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mr_out_valid", bus.out_valid, 1'b0);
        check("mr_core_x_zero", (bus.core_x == '0), 1'b1);
        check("mr_in_ready", bus.in_ready, 1'b1);
        check("mr_nout", mon_data.size(), 5);
        bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) push(32'h500 + k, 1'b0);
        check("mr_core_x0", bus.core_x[W-1:0], 32'h500);
        check("mr_core_x15", bus.core_x[15*W +: W], 32'h50F);
        wait_out(5 + N);
        for (int k = 0; k < 5; k++)
            if (k < mon_data.size()) check($sformatf("mr_pre%0d", k), mon_data[k], 32'h300 + k);
        check_frame("mr_new", 5, 32'h500);

        // Output scaling
        clear_mon();
        push(32'h8000_0010, 1'b0);
        push(32'hFFF0_0020, 1'b0);
        push(32'h0011_FFFF, 1'b0);
        for (int k = 3; k < N; k++) push(32'h0, 1'b0);
        wait_out(N);
`ifdef FFT_OUT_SCALE_EN
        exp0 = 32'hF800_0001;
        exp1 = 32'hFFFF_0002;
        exp2 = 32'h0001_FFFF;
`else
        exp0 = 32'h8000_0010;
        exp1 = 32'hFFF0_0020;
        exp2 = 32'h0011_FFFF;
`endif
        if (mon_data.size() >= 4) begin
            check("scale_s0", mon_data[0], exp0);
            check("scale_s1", mon_data[1], exp1);
            check("scale_s2", mon_data[2], exp2);
            check("scale_s3", mon_data[3], 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
